uart_rx: RTL and testbench

Serial receive stage of the UART, directly downstream of the baud generator. It consumes the 16x-oversampling tick pulse and the asynchronous `rx` line, and recovers 8N1 frames by sampling each bit at mid-bit. Received bytes are presented on a valid/ready output register with framing-error and overrun reporting.

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronizer, mid-bit sampling FSM, valid/ready output register.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err output.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = $clog2(DATA_BITS);
    localparam logic [TCNT_W-1:0] T_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] T_END  = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   stop_hit;
    logic                   take;
    logic                   good;
    logic                   load;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   par_fault;
`endif

    // Synchronizer flops idle high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        stop_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tcnt_q == T_MID) begin
                        tcnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            bcnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tcnt_q == T_END) begin
                        tcnt_d = '0;
                        sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
                        bcnt_d = bcnt_q + BCNT_W'(1);
                        if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tcnt_q == T_END) begin
                        tcnt_d  = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so the next start edge has half a bit of margin
                if (s_tick) begin
                    if (tcnt_q == T_END) begin
                        tcnt_d   = '0;
                        stop_hit = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_fault = ^{sh_q, par_q};
    assign good      = stop_hit & rx_s & ~par_fault;
`else
    assign good      = stop_hit & rx_s;
`endif
    assign take = rx_valid & rx_ready;
    assign load = good & (~rx_valid | take);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            frame_err <= stop_hit & ~rx_s;
            overrun   <= good & rx_valid & ~rx_ready;
            rx_valid  <= load | (rx_valid & ~take);
            if (load) begin
                rx_data <= sh_q;
            end
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            parity_err <= stop_hit & rx_s & par_fault;
`endif
        end
    end

    // Shift register carries data only; no reset needed
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx, checked against a frame-level reference model.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tick   (s_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // One tick every four clocks
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    // Observation log
    logic [7:0] got_q[$];
    int  fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, long_cnt = 0, both_cnt = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if ((frame_err && fe_prev) || (overrun && ov_prev)) long_cnt++;
        fe_prev = frame_err;
        ov_prev = overrun;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
        if (parity_err && pe_prev) long_cnt++;
        if (parity_err && frame_err) both_cnt++;
        pe_prev = parity_err;
`endif
    end

    // Frame-level reference model
    logic [7:0] exp_q[$];
    int   exp_fe = 0, exp_ov = 0, exp_pe = 0;
    bit   held = 1'b0;
    logic [7:0] held_byte = 8'h00;

    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (!stop_ok) exp_fe++;
        else if (!par_ok) exp_pe++;
        else if (held) exp_ov++;
        else if (rx_ready) exp_q.push_back(d);
        else begin
            held      = 1'b1;
            held_byte = d;
        end
    endtask

    task automatic model_ready();
        if (held) begin
            exp_q.push_back(held_byte);
            held = 1'b0;
        end
    endtask

    int passed = 0, total = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        check({tag, "_frame_err_cnt"}, fe_cnt, exp_fe);
        check({tag, "_overrun_cnt"}, ov_cnt, exp_ov);
        check({tag, "_byte_cnt"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        check({tag, "_pulse_width"}, long_cnt, 0);
        check({tag, "_exclusive"}, both_cnt, 0);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err_cnt"}, pe_cnt, exp_pe);
`endif
    endtask

    task automatic drive_bit(input logic b, input int clks);
        rx = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    // par_flip only has an effect when the parity bit is compiled in
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
        bit par_ok;
        par_ok = 1'b1;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip, BIT_CLKS);
        par_ok = !par_flip;
`endif
        if (stop_ok) begin
            drive_bit(1'b1, BIT_CLKS);
        end else begin
            // Short low stop bit so the line is high again before the retriggered start check
            drive_bit(1'b0, 44);
            drive_bit(1'b1, 60);
        end
        model_frame(d, stop_ok, par_ok);
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b0;
        drive_bit(1'b1, 40);

        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        check_state("a5");
        check("a5_valid_cleared", rx_valid, 0);

        drive_bit(1'b0, 12);
        drive_bit(1'b1, 100);
        check_state("glitch");
        send_frame(8'h3C, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        check_state("after_glitch");

        send_frame(8'h55, 1'b0, 1'b0);
        drive_bit(1'b1, 32);
        check_state("framing");
        check("framing_no_valid", rx_valid, 0);

        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        check("hold_valid", rx_valid, 1);
        check("hold_data", rx_data, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        check("overrun_valid", rx_valid, 1);
        check("overrun_data", rx_data, 8'h11);
        check_state("overrun");
        rx_ready = 1'b1;
        model_ready();
        drive_bit(1'b1, 8);
        check("drain_valid", rx_valid, 0);
        check_state("drain");

        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_CLKS);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        drive_bit(1'b1, 200);
        check_state("midrst_quiet");
        send_frame(8'h81, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        check_state("after_rst");
        check("after_rst_data", rx_data, 8'h81);

        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, 1'b0);
            drive_bit(1'b1, $urandom_range(0, 80));
            check_state("random");
        end

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, 32);
        check_state("parity_good");
        check("parity_good_data", rx_data, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, 32);
        check_state("parity_bad");
        check("parity_bad_valid", rx_valid, 0);
`endif

        drive_bit(1'b1, 100);
        check_state("final");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
